// File: rtl/fp_pkg.sv
// Shared binary32 types and stream-max FSM states.
package fp_pkg;

    localparam int unsigned FP_W   = 32;
    localparam int unsigned EXP_W  = 8;
    localparam int unsigned FRAC_W = 23;

    typedef logic [FP_W-1:0] fp32_t;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DONE
    } state_e;

endpackage

// File: rtl/fp_gt.sv
// Combinational binary32 greater-than using a sign-folded unsigned key.
module fp_gt
    import fp_pkg::*;
(
    input  fp32_t a_i,
    input  fp32_t b_i,
    output logic  gt_o
);

    fp32_t key_a;
    fp32_t key_b;

    // Positives get the top bit set, negatives are inverted so magnitude order reverses.
    assign key_a = a_i[FP_W-1] ? ~a_i : (a_i | {1'b1, {(FP_W-1){1'b0}}});
    assign key_b = b_i[FP_W-1] ? ~b_i : (b_i | {1'b1, {(FP_W-1){1'b0}}});
    assign gt_o  = key_a > key_b;

endmodule

// File: rtl/fp_stream_max.sv
// Burst reduction: running max (and min with FP_STREAM_MAX_TRACK_MIN_EN) over N_SAMPLES
// binary32 words, reported with a one-cycle done pulse.
module fp_stream_max
    import fp_pkg::*;
#(
    parameter int unsigned N_SAMPLES = 8,
    parameter int unsigned IDX_W     = $clog2(N_SAMPLES)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  fp32_t            in_data_i,
    output logic             busy_o,
    output logic             done_o,
`ifdef FP_STREAM_MAX_TRACK_MIN_EN
    output fp32_t            min_out_o,
    output logic [IDX_W-1:0] min_idx_o,
`endif
    output fp32_t            max_out_o,
    output logic [IDX_W-1:0] max_idx_o
);

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N_SAMPLES - 1);

    state_e           state_q;
    logic [IDX_W-1:0] count_q;
    fp32_t            run_max_q, run_max_d;
    logic [IDX_W-1:0] run_max_idx_q, run_max_idx_d;
    logic             accept;
    logic             first;
    logic             max_gt;

    assign accept = in_valid_i && in_ready_o;
    assign first  = (count_q == '0);

    fp_gt u_gt_max (
        .a_i  (in_data_i),
        .b_i  (run_max_q),
        .gt_o (max_gt)
    );

    always_comb begin
        run_max_d     = run_max_q;
        run_max_idx_d = run_max_idx_q;
        if (accept && (first || max_gt)) begin
            run_max_d     = in_data_i;
            run_max_idx_d = count_q;
        end
    end

`ifdef FP_STREAM_MAX_TRACK_MIN_EN
    fp32_t            run_min_q, run_min_d;
    logic [IDX_W-1:0] run_min_idx_q, run_min_idx_d;
    fp32_t            min_out_q;
    logic [IDX_W-1:0] min_idx_q;
    logic             min_gt;

    fp_gt u_gt_min (
        .a_i  (run_min_q),
        .b_i  (in_data_i),
        .gt_o (min_gt)
    );

    always_comb begin
        run_min_d     = run_min_q;
        run_min_idx_d = run_min_idx_q;
        if (accept && (first || min_gt)) begin
            run_min_d     = in_data_i;
            run_min_idx_d = count_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            run_min_q     <= '0;
            run_min_idx_q <= '0;
            min_out_q     <= '0;
            min_idx_q     <= '0;
        end else begin
            run_min_q     <= run_min_d;
            run_min_idx_q <= run_min_idx_d;
            if (state_q == COLLECT && accept && count_q == LastIdx) begin
                min_out_q <= run_min_d;
                min_idx_q <= run_min_idx_d;
            end
        end
    end

    assign min_out_o = min_out_q;
    assign min_idx_o = min_idx_q;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            count_q       <= '0;
            run_max_q     <= '0;
            run_max_idx_q <= '0;
            in_ready_o    <= 1'b0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            max_out_o     <= '0;
            max_idx_o     <= '0;
        end else begin
            run_max_q     <= run_max_d;
            run_max_idx_q <= run_max_idx_d;
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q    <= COLLECT;
                        count_q    <= '0;
                        in_ready_o <= 1'b1;
                        busy_o     <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        count_q <= count_q + 1'b1;
                        // Final sample: publish the result including this word.
                        if (count_q == LastIdx) begin
                            state_q    <= DONE;
                            in_ready_o <= 1'b0;
                            done_o     <= 1'b1;
                            max_out_o  <= run_max_d;
                            max_idx_o  <= run_max_idx_d;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_o  <= 1'b0;
                    busy_o  <= 1'b0;
                end
                default: begin
                    state_q    <= IDLE;
                    in_ready_o <= 1'b0;
                    busy_o     <= 1'b0;
                    done_o     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_stream_max.sv
// Directed bench for fp_stream_max with a burst-level reference model (N_SAMPLES=4).
module tb_fp_stream_max;

    localparam int N  = 4;
    localparam int IW = 2;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          start_i = 1'b0;
    logic          in_valid_i = 1'b0;
    logic          in_ready_o;
    logic [31:0]   in_data_i = '0;
    logic          busy_o;
    logic          done_o;
    logic [31:0]   max_out_o;
    logic [IW-1:0] max_idx_o;
`ifdef FP_STREAM_MAX_TRACK_MIN_EN
    logic [31:0]   min_out_o;
    logic [IW-1:0] min_idx_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    fp_stream_max #(.N_SAMPLES(N)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .in_data_i  (in_data_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
`ifdef FP_STREAM_MAX_TRACK_MIN_EN
        .min_out_o  (min_out_o),
        .min_idx_o  (min_idx_o),
`endif
        .max_out_o  (max_out_o),
        .max_idx_o  (max_idx_o)
    );

    always #5 clk_i = ~clk_i;

    // Total order on binary32 words as an unsigned key.
    function automatic logic [31:0] key(input logic [31:0] w);
        return w[31] ? ~w : (w | 32'h8000_0000);
    endfunction

    // Model: phase 0 idle, 1 collecting, 2 done; result from the whole captured burst.
    int          m_phase = 0;
    logic [31:0] m_q[$];
    logic [31:0] m_max = '0;
    int          m_max_idx = 0;
    logic [31:0] m_min = '0;
    int          m_min_idx = 0;

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_phase = 0;
            m_q.delete();
            m_max = '0; m_max_idx = 0; m_min = '0; m_min_idx = 0;
        end else begin
            case (m_phase)
                0: if (start_i) begin m_phase = 1; m_q.delete(); end
                1: if (in_valid_i) begin
                    m_q.push_back(in_data_i);
                    if (m_q.size() == N) begin
                        m_phase = 2;
                        m_max_idx = 0; m_min_idx = 0;
                        for (int i = 1; i < N; i++) begin
                            if (key(m_q[i]) > key(m_q[m_max_idx])) m_max_idx = i;
                            if (key(m_q[i]) < key(m_q[m_min_idx])) m_min_idx = i;
                        end
                        m_max = m_q[m_max_idx];
                        m_min = m_q[m_min_idx];
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_i) begin
        chk("in_ready", {31'b0, in_ready_o}, {31'b0, m_phase == 1});
        chk("busy", {31'b0, busy_o}, {31'b0, m_phase != 0});
        chk("done", {31'b0, done_o}, {31'b0, m_phase == 2});
        chk("max_out", max_out_o, m_max);
        chk("max_idx", {30'b0, max_idx_o}, 32'(m_max_idx));
`ifdef FP_STREAM_MAX_TRACK_MIN_EN
        chk("min_out", min_out_o, m_min);
        chk("min_idx", {30'b0, min_idx_o}, 32'(m_min_idx));
`endif
    end

    task automatic do_start();
        @(posedge clk_i); #1 start_i = 1'b1;
        @(posedge clk_i); #1 start_i = 1'b0;
    endtask

    // Sends up to cnt samples; pat gives in_valid for the first 7 cycles, then held high.
    task automatic send(input logic [31:0] d0, d1, d2, d3, input logic [6:0] pat, input int cnt);
        logic [31:0] d[4];
        int i = 0;
        int k = 0;
        logic rdy;
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        while (i < cnt && k < 40) begin
            in_valid_i = (k < 7) ? pat[6 - k] : 1'b1;
            in_data_i  = in_valid_i ? d[i] : 32'hDEAD_BEEF;
            @(negedge clk_i); rdy = in_ready_o;
            @(posedge clk_i);
            if (in_valid_i && rdy) i++;
            k++;
            #1;
        end
        in_valid_i = 1'b0;
        if (i < cnt) begin
            n_tests++; n_fail++;
            $display("FAIL send_timeout: accepted %0d required %0d", i, cnt);
        end
    endtask

    task automatic wait_done(input string name, input logic [31:0] emax, input int eidx,
                             input logic [31:0] emin, input int emin_idx);
        bit got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk_i);
            if (done_o) got = 1;
        end
        if (!got) begin
            n_tests++; n_fail++;
            $display("FAIL %s_done_timeout: done not seen, required 1", name);
        end else begin
            chk({name, "_max"}, max_out_o, emax);
            chk({name, "_idx"}, {30'b0, max_idx_o}, 32'(eidx));
`ifdef FP_STREAM_MAX_TRACK_MIN_EN
            chk({name, "_min"}, min_out_o, emin);
            chk({name, "_min_idx"}, {30'b0, min_idx_o}, 32'(emin_idx));
`else
            if (emin === 32'hx || emin_idx < 0) $display("unused");
`endif
        end
    endtask

    initial begin
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        chk("reset_max", max_out_o, 32'h0);
        chk("reset_busy", {31'b0, busy_o}, 32'h0);

        do_start();
        send(32'h3F800000, 32'hC0400000, 32'h40000000, 32'h3F000000, 7'h7F, 4);
        wait_done("basic", 32'h40000000, 2, 32'hC0400000, 1);

        do_start();
        send(32'hC0400000, 32'hBF800000, 32'hC0400000, 32'hC0A00000, 7'h7F, 4);
        wait_done("negative", 32'hBF800000, 1, 32'hC0A00000, 3);

        do_start();
        send(32'h40000000, 32'h40000000, 32'h3F800000, 32'h3F800000, 7'h7F, 4);
        wait_done("ties", 32'h40000000, 0, 32'h3F800000, 2);

        do_start();
        send(32'h80000000, 32'h00000000, 32'h80000000, 32'h80000000, 7'h7F, 4);
        wait_done("zero", 32'h00000000, 1, 32'h80000000, 0);

        do_start();
        send(32'h3F800000, 32'hC0400000, 32'h40000000, 32'h3F000000, 7'b1001011, 4);
        wait_done("gaps", 32'h40000000, 2, 32'hC0400000, 1);

        do_start();
        send(32'h7F000000, 32'h7F100000, 32'h0, 32'h0, 7'h7F, 2);
        #2 rst_i = 1'b1;
        #1;
        chk("midrst_ready", {31'b0, in_ready_o}, 32'h0);
        chk("midrst_busy", {31'b0, busy_o}, 32'h0);
        chk("midrst_max", max_out_o, 32'h0);
        chk("midrst_idx", {30'b0, max_idx_o}, 32'h0);
        @(posedge clk_i); #1 rst_i = 1'b0;
        do_start();
        send(32'h3F800000, 32'hC0400000, 32'h40000000, 32'h3F000000, 7'h7F, 4);
        wait_done("fresh", 32'h40000000, 2, 32'hC0400000, 1);

        // start held through COLLECT and the DONE cycle must not restart the burst.
        @(posedge clk_i); #1 start_i = 1'b1;
        @(posedge clk_i); #1;
        send(32'h3F000000, 32'h3F800000, 32'h3E800000, 32'h3F800000, 7'h7F, 4);
        wait_done("start_held", 32'h3F800000, 1, 32'h3E800000, 2);
        @(posedge clk_i); #1 start_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("idle_ready", {31'b0, in_ready_o}, 32'h0);
        chk("idle_busy", {31'b0, busy_o}, 32'h0);
        chk("idle_max_hold", max_out_o, 32'h3F800000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_stream_max.md
Name: fp_stream_max

Overview:
- Sequential reduction stage downstream of the single-precision greater-than comparator.
- Accepts a burst of N_SAMPLES IEEE-754 binary32 words over a valid/ready stream.
- Tracks the running maximum and its index, then reports both with a one-cycle done pulse.
- Feeds the result registers used by the week-3 datapath for peak selection.

Parameters:
- N_SAMPLES, 8, samples per burst; legal range 2..256.
- IDX_W, $clog2(N_SAMPLES), width of the index outputs and the sample counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  begin a burst; sampled only in IDLE
- in_valid  input  1  in_data is valid
- in_ready  output  1  block accepts in_data this cycle
- in_data  input  32  binary32 sample
- busy  output  1  high in COLLECT and DONE
- done  output  1  one-cycle pulse; result valid
- max_out  output  32  maximum sample of the last completed burst
- max_idx  output  IDX_W  index (0-based) of max_out within the burst

Behaviour:
- Reset: the design has one clock (clk). Reset (rst) is asynchronous and active-high. On reset, the state goes to IDLE and all outputs are 0: in_ready, busy, done, max_out, max_idx, and the counter.
- FSM states: IDLE, COLLECT, DONE.
  - IDLE: in_ready=0, busy=0. If start=1, go to COLLECT and set count=0.
  - COLLECT: in_ready=1, busy=1. A sample is accepted when in_valid && in_ready.
    - Acceptance with count==0: unconditionally load the running max with in_data and set the running index to 0.
    - Acceptance with count>0: replace the running max only if gt(in_data, running max) is true, and set the running index to count.
    - Every acceptance increments count. On acceptance with count==N_SAMPLES-1, go to DONE.
  - DONE: in_ready=0, busy=1, done=1 for exactly one cycle. max_out and max_idx update from the running registers in the same cycle. Then go to IDLE.
- Latency: done asserts in the cycle after the final sample is accepted.
- Gaps in in_valid are allowed. No sample is lost or duplicated, and the counter holds across gaps.
- start outside IDLE is ignored. start coincident with the DONE cycle is also ignored; the next burst needs start in IDLE.
- max_out and max_idx are stable from done until the next DONE. They are not cleared by start.
- Ordering rule gt(a,b):
  - Form a 32-bit key for each operand. If bit31=0, key = word with bit31 set. If bit31=1, key = ~word.
  - gt is true when key(a) > key(b), compared as unsigned.
  - Consequences: negatives order by reversed magnitude, and -0 < +0.
  - NaN and Inf get no special handling; they order by key.
- Ties are strict. An equal later sample does not replace the max, so the earliest index wins.
- Reset mid-burst: discard the partial result and return to IDLE with all outputs 0.

Optional Feature:
- Macro: FP_STREAM_MAX_TRACK_MIN_EN.
- When defined:
  - Add output ports min_out (32) and min_idx (IDX_W).
  - Minimum uses gt(running min, in_data) with the same tie rule, load-on-first behaviour, reset value and update timing as the maximum.
- When undefined:
  - The ports are absent and no minimum logic is present.

Decomposition:
- Shared package fp_pkg:
  - FP_W=32, EXP_W=8, FRAC_W=23.
  - The fp32_t typedef.
  - The state enum {IDLE, COLLECT, DONE}.
- One sub-module, fp_gt: purely combinational, inputs a and b (32 bits each), output gt, implementing the key rule above.
  - Instantiated once for max, and once more for min when FP_STREAM_MAX_TRACK_MIN_EN is defined.

Test Plan:
- N=4, start, stream 3F800000, C0400000, 40000000, 3F000000 back-to-back -> done exactly 1 cycle after 4th accept; max_out=40000000, max_idx=2.
- All negative: BF800000 (-1.0) at index 1, with C0400000, C0400000, C0A00000 at indices 0, 2, 3 -> max_out=BF800000, max_idx=1. With the MIN feature: min_out=C0A00000, min_idx=3.
- Ties: 40000000, 40000000, 3F800000, 3F800000 -> max_idx=0. Signed zero: 80000000, 00000000, 80000000, 80000000 -> max_out=00000000, max_idx=1.
- Backpressure/gaps: in_valid toggles 1,0,0,1,0,1,1 with 4 samples -> exactly 4 accepts; done asserts only after the 4th; result matches the gapless run.
- Reset mid-burst: assert rst after 2 accepts -> immediately in_ready=0, busy=0, max_out=0, max_idx=0. A following full burst gives the correct fresh result.
- start pulsed during COLLECT and in the DONE cycle -> no restart and no count change; after DONE the FSM sits in IDLE with in_ready=0 until a new start.
